// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch stage and the decoder.
// Holds the opcode match values, the FSM state encoding, the reset PC and
// a helper that classifies an opcode byte into a control-flow operation.
package pc_sequencer_pkg;

    // Opcode match values, compared against the top bits of instr[15:8]
    localparam logic [4:0] OPC_JMP = 5'b00100;
    localparam logic [4:0] OPC_JZE = 5'b00101;
    localparam logic [4:0] OPC_JNE = 5'b00110;
    localparam logic [4:0] OPC_JCY = 5'b00111;
    localparam logic [5:0] OPC_BSR = 6'b000111;
    localparam logic [7:0] OPC_RET = 8'h41;
    localparam logic [7:0] OPC_NOP = 8'h00;

    localparam int RESET_PC = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_SEQ,
        OP_JMP,
        OP_JZE,
        OP_JNE,
        OP_JCY,
        OP_BSR,
        OP_RET
    } op_t;

    // Classify the opcode byte; anything unrecognised just advances the PC.
    function automatic op_t decode_op(input logic [7:0] opc);
        if (opc[7:3] == OPC_JMP)      return OP_JMP;
        else if (opc[7:3] == OPC_JZE) return OP_JZE;
        else if (opc[7:3] == OPC_JNE) return OP_JNE;
        else if (opc[7:3] == OPC_JCY) return OP_JCY;
        else if (opc[7:2] == OPC_BSR) return OP_BSR;
        else if (opc == OPC_RET)      return OP_RET;
        else                          return OP_SEQ;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Program-ROM and decoder bus of the fetch stage.
//   rom_addr    : ROM word address (driven by the sequencer)
//   rom_data    : ROM read data, valid one cycle after rom_addr
//   instr       : instruction register, to the decoder OPCODE input
//   instr_valid : one-cycle pulse when instr is newly loaded
// master = sequencer side, slave = ROM/decoder side.
interface pc_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [15:0]       instr;
    logic              instr_valid;

    modport master (output rom_addr, output instr, output instr_valid, input rom_data);
    modport slave  (input rom_addr, input instr, input instr_valid, output rom_data);
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return stack for BSR/RET.
//   push/pop  : one operation per cycle (push wins if both are high)
//   push_data : return address to store
//   top       : most recently pushed entry (undefined when empty)
//   full/empty: occupancy status
//   ovf/unf   : sticky error flags, cleared only by rst
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   sp;          // 0..DEPTH, one bit wider than an index

    assign full  = (sp == (PTR_W+1)'(DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[PTR_W'(sp - (PTR_W+1)'(1))];

    // NOTE: the entry array has no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[PTR_W'(sp)] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            if (full) ovf <= 1'b1;
            else      sp  <= sp + (PTR_W+1)'(1);
        end else if (pop) begin
            if (empty) unf <= 1'b1;
            else       sp  <= sp - (PTR_W+1)'(1);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch stage: owns the PC, fetches from the synchronous ROM,
// holds the instruction register and resolves all control flow locally.
// Each instruction takes FETCH -> LOAD -> EXEC.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : freezes FSM, PC, IR and stack
//   bus             : ROM address/data, instr, instr_valid
//   w_zero/w_sign/cy: datapath flags, sampled in EXEC
//   pc              : current program counter
//   stk_ovf/stk_unf : sticky return-stack overflow / underflow
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int STK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    pc_sequencer_if.master    bus,
    input  logic              w_zero,
    input  logic              w_sign,
    input  logic              cy,
    output logic [ADDR_W-1:0] pc,
    output logic              stk_ovf,
    output logic              stk_unf
);
    state_t              state;
    op_t                 op;
    logic                exec_go;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   jmp_target;
    logic [ADDR_W-1:0]   bsr_target;
    logic signed [9:0]   bsr_off;
    logic [ADDR_W-1:0]   next_pc;
    logic [ADDR_W-1:0]   stk_top;
    logic                stk_full;
    logic                stk_empty;

    assign op         = decode_op(bus.instr[15:8]);
    assign exec_go    = (state == EXEC) && !stall;
    assign push       = exec_go && (op == OP_BSR);
    assign pop        = exec_go && (op == OP_RET);
    assign pc_inc     = pc + ADDR_W'(1);
    assign jmp_target = bus.instr[ADDR_W-1:0];
    assign bsr_off    = signed'(bus.instr[9:0]);
    // Sign-extended offset; the add wraps modulo 2^ADDR_W.
    assign bsr_target = pc + ADDR_W'(bsr_off);

    // NOTE: every branch assigns next_pc because of the default above the case, so no latch.
    always_comb begin
        next_pc = pc_inc;
        case (op)
            OP_JMP:  next_pc = jmp_target;
            OP_JZE:  next_pc = w_zero  ? jmp_target : pc_inc;
            OP_JNE:  next_pc = !w_sign ? jmp_target : pc_inc;
            OP_JCY:  next_pc = cy      ? jmp_target : pc_inc;
            OP_BSR:  next_pc = bsr_target;                  // taken even on overflow
            OP_RET:  next_pc = stk_empty ? pc_inc : stk_top; // underflow acts as NOP
            default: next_pc = pc_inc;
        endcase
    end

    return_stack #(
        .DEPTH (STK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

    // rom_addr is updated together with pc, so it equals pc throughout FETCH
    // while still being a plain register output.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= FETCH;
            pc              <= ADDR_W'(RESET_PC);
            bus.rom_addr    <= ADDR_W'(RESET_PC);
            bus.instr       <= {OPC_NOP, 8'h00};
            bus.instr_valid <= 1'b0;
        end else if (stall) begin
            bus.instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    bus.instr_valid <= 1'b0;
                    state           <= LOAD;
                end
                LOAD: begin
                    bus.instr       <= bus.rom_data;
                    bus.instr_valid <= 1'b1;
                    state           <= EXEC;
                end
                EXEC: begin
                    bus.instr_valid <= 1'b0;
                    pc              <= next_pc;
                    bus.rom_addr    <= next_pc;
                    state           <= FETCH;
                end
                default: begin
                    bus.instr_valid <= 1'b0;
                    state           <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and fetches 16-bit words from the synchronous program ROM, then holds them in an instruction register that drives the decoder OPCODE input.
- Resolves all control flow locally: JMP, JZE, JNE, JCY, BSR and RET, the last two through a hardware return stack.
- Every instruction takes 3 cycles: FETCH, LOAD, EXEC.

Parameters:
ADDR_W, 10, program counter and ROM address width (1024 words)
STK_DEPTH, 8, return stack entries (power of two, at least 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  freezes FSM, PC, IR and stack while high
rom_addr  out  ADDR_W  program ROM address (ROM has 1-cycle read latency)
rom_data  in  16  ROM read data, valid the cycle after rom_addr
instr  out  16  instruction register, to decoder OPCODE
instr_valid  out  1  one-cycle pulse in the cycle instr is newly loaded
w_zero  in  1  working register equals 0, from datapath
w_sign  in  1  working register bit 15
cy  in  1  carry flag
pc  out  ADDR_W  current program counter
stk_ovf  out  1  sticky: BSR with stack full
stk_unf  out  1  sticky: RET with stack empty

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-instruction): pc=0, instr=16'h0000 (NOP), instr_valid=0, rom_addr=0, stack pointer=0, stk_ovf=0, stk_unf=0, state=FETCH.
- FSM states and transitions: FETCH -> LOAD -> EXEC -> FETCH. With stall=1 the state holds and no register changes. instr_valid is forced to 0 during a stall.
- FETCH: rom_addr=pc.
- LOAD: instr <= rom_data; instr_valid=1 in the following cycle only.
- EXEC: next PC is selected from instr[15:8]:
  - 00100xxx JMP: pc <= instr[ADDR_W-1:0].
  - 00101xxx JZE: pc <= target if w_zero, else pc+1.
  - 00110xxx JNE: pc <= target if w_sign==0, else pc+1.
  - 00111xxx JCY: pc <= target if cy, else pc+1.
  - 000111xx BSR: push pc+1; pc <= pc + sign-extended instr[9:0].
  - 01000001 RET: pop; pc <= popped value.
  - All other codes: pc <= pc+1.
- Flag sampling: w_zero, w_sign and cy are sampled in EXEC. They reflect the previous instruction's result, because the datapath commits during LOAD/EXEC of that instruction.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W. pc+1 at the maximum address wraps to 0, and BSR offsets wrap the same way.
- Stack: STK_DEPTH x ADDR_W register array with pointer sp in 0..STK_DEPTH.
  - Push writes entry[sp] and increments sp; pop decrements sp and reads entry[sp-1].
  - BSR when sp==STK_DEPTH: no write, sp unchanged, stk_ovf<=1, branch still taken.
  - RET when sp==0: pc <= pc+1 (treated as NOP), stk_unf<=1.
  - stk_ovf and stk_unf clear only on rst.
- Outputs: pc and rom_addr are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - opcode masks/values: OPC_JMP=5'b00100, OPC_JZE=5'b00101, OPC_JNE=5'b00110, OPC_JCY=5'b00111, OPC_BSR=6'b000111, OPC_RET=8'h41, OPC_NOP=8'h00
  - state encoding: FETCH=2'd0, LOAD=2'd1, EXEC=2'd2
  - the reset PC
- The decoder consumes the same opcode constants from this package.
- One sub-module: return_stack (push, pop, full, empty, data out, sticky error flags), instantiated with STK_DEPTH and ADDR_W.

Test Plan:
- Sequential run: ROM[0..2]=NOP; release reset -> instr_valid pulses every 3 cycles; pc goes 0,1,2,3; rom_addr matches pc during FETCH.
- JMP: ROM[3]=16'h2155 -> pc=0x155 after EXEC, next rom_addr=0x155. JZE 0x020 with w_zero=0 -> pc=prev+1; with w_zero=1 -> pc=0x020. Same checks for JNE (w_sign) and JCY (cy).
- BSR/RET: pc=0x010 executes BSR with S=-4 (instr[9:0]=10'h3FC) -> pc=0x00C, stack top=0x011. A later RET -> pc=0x011 and sp returns to 0.
- Stack overflow: 9 nested BSR with STK_DEPTH=8 -> stk_ovf=1 after the 9th, branch taken. 8 RETs return in LIFO order, then a 9th RET -> stk_unf=1 and pc=pc+1.
- Wrap and stall: pc=0x3FF NOP -> pc=0x000. Hold stall high for 5 cycles in LOAD -> instr unchanged, no instr_valid pulse, resumes exactly where it stopped.
- Async reset: assert rst mid-EXEC of a BSR, between clock edges -> all outputs reset immediately, stack empty, next fetch from 0.
